// File: rtl/soc_system_nios2_gen2_0_cpu_debug_host_pkg.sv
// Shared types and constants for the Nios II debug host.
// Optional run-test-idle dwell: DEBUG_HOST_RTI_EN.
package soc_system_nios2_gen2_0_cpu_debug_host_pkg;

    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACE     = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_system_nios2_gen2_0_cpu_debug_host_tckgen.sv
// Virtual TCK strobe divider: one tck_en every CLK_DIV clk cycles.
// Holds its count at zero whenever enable is low.
module soc_system_nios2_gen2_0_cpu_debug_host_tckgen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tck_en
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Count clk cycles while enabled, wrapping at the divide point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable || cnt == DIV_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tck_en = enable && (cnt == DIV_LAST);

endmodule

// File: rtl/soc_system_nios2_gen2_0_cpu_debug_host.sv
// Virtual JTAG debug host: IR update, DR capture/shift/update per command.
// Macro DEBUG_HOST_RTI_EN adds a run-test-idle dwell after update-DR.
module soc_system_nios2_gen2_0_cpu_debug_host
    import soc_system_nios2_gen2_0_cpu_debug_host_pkg::*;
#(
    parameter int DR_WIDTH   = DR_WIDTH_DEF,
    parameter int IR_WIDTH   = IR_WIDTH_DEF,
    parameter int CLK_DIV    = 1,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ir_en,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                tck_en,
    output logic                tdi,
    input  logic                tdo,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                busy
);

    localparam int CNT_MAX = max_int(DR_WIDTH, RTI_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DR_LAST = CW'(DR_WIDTH - 1);
`ifdef DEBUG_HOST_RTI_EN
    localparam logic [CW-1:0] RTI_LAST = CW'(RTI_CYCLES - 1);
`endif

    state_t              state;
    state_t              state_nxt;
    logic [DR_WIDTH-1:0] sr;
    logic [CW-1:0]       cnt;
    logic                accept;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    soc_system_nios2_gen2_0_cpu_debug_host_tckgen #(
        .CLK_DIV(CLK_DIV)
    ) u_tckgen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (busy),
        .tck_en (tck_en)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: scan steps advance only on TCK strobes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = cmd_ir_en ? ST_UIR : ST_CDR;
                end
            end
            ST_UIR: begin
                if (tck_en) state_nxt = ST_CDR;
            end
            ST_CDR: begin
                if (tck_en) state_nxt = ST_SDR;
            end
            ST_SDR: begin
                if (tck_en && cnt == DR_LAST) state_nxt = ST_UDR;
            end
            ST_UDR: begin
`ifdef DEBUG_HOST_RTI_EN
                if (tck_en) state_nxt = ST_RTI;
`else
                if (tck_en) state_nxt = ST_DONE;
`endif
            end
`ifdef DEBUG_HOST_RTI_EN
            ST_RTI: begin
                if (tck_en && cnt == RTI_LAST) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load on accept; shift tdo into the MSB on each SDR step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr    <= '0;
            cnt   <= '0;
            ir_in <= '0;
        end else if (accept) begin
            sr  <= cmd_dr;
            cnt <= '0;
            if (cmd_ir_en) ir_in <= cmd_ir;
        end else if (tck_en) begin
            if (state == ST_SDR) begin
                sr  <= {tdo, sr[DR_WIDTH-1:1]};
                cnt <= (cnt == DR_LAST) ? '0 : cnt + 1'b1;
            end
`ifdef DEBUG_HOST_RTI_EN
            else if (state == ST_RTI) begin
                cnt <= cnt + 1'b1;
            end
`endif
        end
    end

    assign tdi       = (state == ST_SDR) & sr[0];
    assign rsp_dr    = sr;
    assign rsp_valid = (state == ST_DONE);
    assign vs_uir    = (state == ST_UIR);
    assign vs_cdr    = (state == ST_CDR);
    assign vs_sdr    = (state == ST_SDR);
    assign vs_udr    = (state == ST_UDR);
`ifdef DEBUG_HOST_RTI_EN
    assign jtag_state_rti = (state == ST_RTI);
`else
    assign jtag_state_rti = 1'b0;
`endif

endmodule

// File: doc/soc_system_nios2_gen2_0_cpu_debug_host.md
SOC_SYSTEM_NIOS2_GEN2_0_CPU_DEBUG_HOST -- requirements
Module: soc_system_nios2_gen2_0_cpu_debug_host

Interface
REQ-001 Parameter DR_WIDTH, default 38, debug data-register shift length in bits.
REQ-002 Parameter IR_WIDTH, default 2, virtual instruction-register width.
REQ-003 Parameter CLK_DIV, default 1, clk cycles per virtual TCK step; legal range 1..255.
REQ-004 Parameter RTI_CYCLES, default 2, TCK steps spent in run-test-idle; used only when DEBUG_HOST_RTI_EN is defined.
REQ-005 clk  in  1  system clock; all logic SHALL be on rising edge of clk only.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid / cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_ir_en  in  1  1 = perform IR update before DR scan; 0 = skip IR update.
REQ-009 cmd_ir  in  IR_WIDTH  IR value to load.
REQ-010 cmd_dr  in  DR_WIDTH  data shifted out on tdi, LSB first.
REQ-011 rsp_valid / rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_dr  out  DR_WIDTH  bits captured from tdo.
REQ-013 ir_in  out  IR_WIDTH  IR value presented to the debug slave.
REQ-014 tck_en  out  1  one-clk strobe marking each virtual TCK step.
REQ-015 tdi  out  1; tdo  in  1  serial data to/from debug slave.
REQ-016 vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual JTAG state indicators.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, DONE; transitions other than IDLE->* occur only on cycles where tck_en=1.
REQ-019 tck_en SHALL pulse once every CLK_DIV clk cycles while busy=1; counter restarts at 0 on command acceptance; CLK_DIV=1 gives tck_en=1 every busy cycle.
REQ-020 cmd_ready=1 only in IDLE; cmd_valid&cmd_ready loads cmd_ir/cmd_dr and enters UIR if cmd_ir_en=1, else CDR.
REQ-021 UIR: ir_in<=cmd_ir, vs_uir=1 for one TCK step; ir_in SHALL hold its value until the next UIR.
REQ-022 CDR: vs_cdr=1 for one TCK step, then SDR.
REQ-023 SDR: exactly DR_WIDTH TCK steps; tdi=current shift-register LSB; on each tck_en tdo shifts into the MSB and the register shifts right; after the last step rsp_dr[0] holds the first tdo bit sampled.
REQ-024 UDR: vs_udr=1 for one TCK step, then RTI (if enabled) or DONE.
REQ-025 DONE: rsp_valid=1 with rsp_dr stable until rsp_valid&rsp_ready, then IDLE; rsp_ready ignored in other states.
REQ-026 State indicators SHALL be mutually exclusive (one-hot or all zero).
REQ-027 Latency with CLK_DIV=1, cmd_ir_en=1, RTI off: rsp_valid asserts DR_WIDTH+3 cycles after the accepting cycle (UIR+CDR+DR_WIDTH+UDR); cmd_ir_en=0 subtracts 1.
REQ-028 cmd_valid asserted while busy SHALL be ignored and not queued.
REQ-029 tdi=0 outside SDR.

Reset
REQ-030 reset_n low, at any time including mid-scan, SHALL force IDLE, clear the TCK counter and shift register, and drive ir_in=0, rsp_dr=0, tdi=0, and all handshake, strobe and state outputs to 0, except cmd_ready=1.

Configuration
REQ-031 Macro DEBUG_HOST_RTI_EN defined: UDR->RTI, jtag_state_rti=1 for RTI_CYCLES TCK steps, then DONE; latency increases by RTI_CYCLES*CLK_DIV.
REQ-032 Macro undefined: RTI state absent, UDR->DONE, and jtag_state_rti is tied to 0.

Structure
REQ-033 Package soc_system_nios2_gen2_0_cpu_debug_host_pkg SHALL hold the FSM state enum, the DR/IR default widths, and the IR code constants (OCIMEM, TRACE, BREAK, TRACECTRL).
REQ-034 The TCK strobe divider SHALL be sub-module soc_system_nios2_gen2_0_cpu_debug_host_tckgen (inputs clk, reset_n, enable; output tck_en).

Verification
REQ-035 Reset mid-SDR (bit 17 of 38) -> next cycle: IDLE, cmd_ready=1, all strobes 0, ir_in=0.
REQ-036 CLK_DIV=1, cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_5A5A, tdo looped to tdi -> ir_in=2'b10, rsp_dr=38'h2A_5A5A_5A5A, rsp_valid 41 cycles after acceptance.
REQ-037 cmd_ir_en=0, prior ir_in=2'b01 -> no vs_uir pulse, ir_in remains 2'b01, rsp_valid 40 cycles after acceptance.
REQ-038 CLK_DIV=4 -> each vs_* state lasts 4 cycles, tck_en period 4, 38 tck_en pulses during SDR.
REQ-039 rsp_ready held 0 for 10 cycles, cmd_valid=1 throughout -> rsp_dr stable, cmd_ready=0, no second command accepted until the response handshake.
REQ-040 DEBUG_HOST_RTI_EN defined, RTI_CYCLES=2 -> jtag_state_rti high for 2 cycles after vs_udr; undefined -> jtag_state_rti constantly 0.
